// File: rtl/systolic_writeback.sv
// Quantizing writeback for a 32x32 systolic accumulator tile: deskews skewed lanes, then drains packed int8 rows.
// Optional SYSTOLIC_WB_RELU_EN clamps negative results to zero.
module systolic_writeback #(
  parameter int unsigned ARRAY_SIZE    = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OUTCOME_WIDTH = 21
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wb_start_i,
  input  logic [4:0]                          shift_i,
  input  logic                                acc_valid_i,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome_i,
  output logic [5:0]                          matrix_index_o,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [4:0]                          wb_row_o,
  output logic [31:0]                         sram_wdata0_o,
  output logic [31:0]                         sram_wdata1_o,
  output logic [31:0]                         sram_wdata2_o,
  output logic [31:0]                         sram_wdata3_o,
  output logic [31:0]                         sram_wdata4_o,
  output logic [31:0]                         sram_wdata5_o,
  output logic [31:0]                         sram_wdata6_o,
  output logic [31:0]                         sram_wdata7_o,
  output logic                                busy_o,
  output logic                                wb_done_o,
  output logic [9:0]                          sat_count_o
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MI_W    = 6;
  localparam int unsigned SH_W    = 5;
  localparam int unsigned SAT_W   = 10;
  localparam int unsigned SUM_W   = OUTCOME_WIDTH + 1;
  localparam int unsigned WORDS   = ARRAY_SIZE * DATA_WIDTH / 32;
  localparam int unsigned PER_WD  = 32 / DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(ARRAY_SIZE + 1);
  localparam int unsigned SAT_MAX = (1 << SAT_W) - 1;
  localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [SH_W-1:0]             shift_q, shift_d;
  logic [MI_W-1:0]             mi_q, mi_d;
  logic [SAT_W-1:0]            sat_q, sat_d;
  logic                        valid_q, valid_d;
  logic [IDX_W-1:0]            row_q, row_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic [WORDS-1:0][31:0]      sram_q, sram_d;
  logic [DATA_WIDTH-1:0]       deskew_q [ARRAY_SIZE][ARRAY_SIZE];

  logic                        cap_we;
  logic                        load;
  logic [IDX_W-1:0]            rd_row;
  logic [DATA_WIDTH-1:0]       q_lane [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]       sat_lane;
  logic [CNT_W-1:0]            sat_num;
  logic [SAT_W:0]              sat_sum;
  logic [SAT_W-1:0]            sat_next;

  // Round-half-up arithmetic shift, then clamp to int8; shifts beyond the lane width always round to zero.
  always_comb begin
    logic signed [OUTCOME_WIDTH-1:0] acc_v;
    logic signed [SUM_W-1:0]         sum_v;
    logic signed [SUM_W-1:0]         rnd_v;
    logic signed [SUM_W-1:0]         qv;
    sat_num = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      acc_v = mul_outcome_i[i*OUTCOME_WIDTH +: OUTCOME_WIDTH];
      sum_v = SUM_W'(acc_v);
      rnd_v = SUM_W'(1) <<< (shift_q - SH_W'(1));
      if (shift_q == '0) begin
        qv = sum_v;
      end else if (shift_q > SH_W'(OUTCOME_WIDTH)) begin
        qv = '0;
      end else begin
        qv = (sum_v + rnd_v) >>> shift_q;
      end
      sat_lane[i] = 1'b0;
      q_lane[i]   = qv[DATA_WIDTH-1:0];
      if (qv > Q_MAX) begin
        q_lane[i]   = Q_MAX[DATA_WIDTH-1:0];
        sat_lane[i] = 1'b1;
`ifdef SYSTOLIC_WB_RELU_EN
      end else if (qv < 0) begin
        q_lane[i] = '0;
`else
      end else if (qv < Q_MIN) begin
        q_lane[i]   = Q_MIN[DATA_WIDTH-1:0];
        sat_lane[i] = 1'b1;
`endif
      end
      sat_num = sat_num + CNT_W'(sat_lane[i]);
    end
    sat_sum  = (SAT_W+1)'(sat_q) + (SAT_W+1)'(sat_num);
    sat_next = (sat_sum > (SAT_W+1)'(SAT_MAX)) ? SAT_W'(SAT_MAX) : sat_sum[SAT_W-1:0];
  end

  // Next-state and output register inputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mi_d    = mi_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    row_d   = row_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    cap_we  = 1'b0;
    load    = 1'b0;
    rd_row  = row_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_start_i) begin
          state_d = S_CAPTURE;
          shift_d = shift_i;
          sat_d   = '0;
          mi_d    = '0;
          busy_d  = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (acc_valid_i) begin
          cap_we = 1'b1;
          sat_d  = sat_next;
          if (mi_q == MI_W'(ARRAY_SIZE - 1)) begin
            mi_d    = '0;
            state_d = S_DRAIN;
          end else begin
            mi_d = mi_q + MI_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          row_d   = '0;
          rd_row  = '0;
          load    = 1'b1;
        end else if (wb_ready_i) begin
          if (row_q == IDX_W'(ARRAY_SIZE - 1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            row_d  = row_q + IDX_W'(1);
            rd_row = row_q + IDX_W'(1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pack the selected deskewed row; column 0 lands in the MSB byte of word 0.
  always_comb begin
    sram_d = sram_q;
    if (load) begin
      for (int w = 0; w < WORDS; w++) begin
        for (int b = 0; b < PER_WD; b++) begin
          sram_d[w][31-DATA_WIDTH*b -: DATA_WIDTH] = deskew_q[rd_row][PER_WD*w+b];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      mi_q    <= '0;
      sat_q   <= '0;
      valid_q <= 1'b0;
      row_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sram_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mi_q    <= mi_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sram_q  <= sram_d;
    end
  end

  // Deskew storage is never reset; every tile rewrites all entries before the drain reads them.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        deskew_q[i][IDX_W'(mi_q[IDX_W-1:0] - IDX_W'(i))] <= q_lane[i];
      end
    end
  end

  assign matrix_index_o = mi_q;
  assign wb_valid_o     = valid_q;
  assign wb_row_o       = row_q;
  assign busy_o         = busy_q;
  assign wb_done_o      = done_q;
  assign sat_count_o    = sat_q;
  assign sram_wdata0_o  = sram_q[0];
  assign sram_wdata1_o  = sram_q[1];
  assign sram_wdata2_o  = sram_q[2];
  assign sram_wdata3_o  = sram_q[3];
  assign sram_wdata4_o  = sram_q[4];
  assign sram_wdata5_o  = sram_q[5];
  assign sram_wdata6_o  = sram_q[6];
  assign sram_wdata7_o  = sram_q[7];

endmodule
